// File: rtl/choreo_step_scheduler.sv
// choreo_step_scheduler
// Plays up to eight programmed steps onto an 8-bit pattern bus. Each step has a
// pattern and a dwell time measured in prescaled ticks. The block handles
// start/stop/pause/loop control and refuses host writes while a sequence is playing.
module choreo_step_scheduler #(
  parameter int STEPS = 8,
  parameter int PAT_W = 8,
  parameter int DUR_W = 4,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [PRE_W-1:0] prescale,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [PAT_W-1:0] wr_pattern,
  input  logic [DUR_W-1:0] wr_dur,
  output logic             wr_err,
  input  logic [2:0]       last_step,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [PAT_W-1:0] pattern_out,
  output logic [2:0]       step_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] dwell_q, dwell_d;
  logic [2:0]       idx_d, idx_inc;
  logic [PAT_W-1:0] pat_d;
  logic             wr_ok;

  logic [PAT_W-1:0] pat_mem [STEPS];
  logic [DUR_W-1:0] dur_mem [STEPS];

  assign busy    = (state_q == S_PLAY) || (state_q == S_HOLD);
  assign done    = (state_q == S_DONE);
  assign wr_ok   = wr_en && !busy;
  assign idx_inc = step_idx + 3'd1;

  // Next-state and datapath: stop beats start, start beats pause, pause beats timing.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    pre_d   = pre_q;
    dwell_d = dwell_q;
    idx_d   = step_idx;
    pat_d   = pattern_out;
    if (stop) begin
      state_d = S_IDLE;
      pre_d   = '0;
      dwell_d = '0;
      idx_d   = '0;
      pat_d   = '0;
    end else if (start) begin
      // Reads slot 0 before any same-cycle write lands, so the old contents play.
      state_d = S_PLAY;
      pre_d   = '0;
      dwell_d = '0;
      idx_d   = '0;
      pat_d   = pat_mem[0];
    end else begin
      case (state_q)
        S_PLAY: begin
          if (pause) begin
            state_d = S_HOLD;
          end else if (ena) begin
            if (pre_q == prescale) begin
              pre_d = '0;
              if (dwell_q == dur_mem[step_idx]) begin
                dwell_d = '0;
                if (step_idx != last_step) begin
                  idx_d = idx_inc;
                  pat_d = pat_mem[idx_inc];
                end else if (loop_en) begin
                  idx_d = '0;
                  pat_d = pat_mem[0];
                end else begin
                  state_d = S_DONE;
                end
              end else begin
                dwell_d = dwell_q + 1'b1;
              end
            end else begin
              pre_d = pre_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!pause) state_d = S_PLAY;
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      dwell_q     <= '0;
      step_idx    <= '0;
      pattern_out <= '0;
      wr_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      dwell_q     <= dwell_d;
      step_idx    <= idx_d;
      pattern_out <= pat_d;
      wr_err      <= wr_en && busy;
    end
  end

  // Step slot storage; host writes land only while no sequence is playing.
  always_ff @(posedge clk) begin
    // NOTE: the slots are reset on purpose, because a replay after reset must play all-zero patterns.
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        pat_mem[i] <= '0;
        dur_mem[i] <= '0;
      end
    end else if (wr_ok) begin
      pat_mem[wr_addr] <= wr_pattern;
      dur_mem[wr_addr] <= wr_dur;
    end
  end

endmodule
